onoff_driver: RTL
=================

# onoff_driver

Command-side companion of the ON/OFF (JK-controlled) state machine: it accepts target-state commands over a valid/ready handshake and generates the single-cycle `j`/`k` pulses that move the downstream ON/OFF machine into that state, then holds it for a programmed number of cycles. It keeps an internal model of the downstream state so it issues `j` only from OFF and `k` only from ON. An optional feedback checker compares the downstream `out` against the model.

## Interface
- `HOLD_W`, 8: width of the hold-count field.
- `ERR_W`, 8: width of the saturating mismatch counter.

- `clk`  in  1  rising-edge clock, shared with the downstream ON/OFF machine.
- `reset`  in  1  asynchronous, active-low reset.
- `tgt_valid`  in  1  command present.
- `tgt_ready`  out  1  driver can accept a command.
- `tgt_state`  in  1  target state: 0 = OFF, 1 = ON.
- `tgt_hold`  in  HOLD_W  cycles to hold after reaching target; 0 = no hold.
- `j`  out  1  turn-on request to the downstream machine.
- `k`  out  1  turn-off request to the downstream machine.
- `fb_out`  in  1  downstream machine `out`, registered on `clk`.
- `busy`  out  1  command in progress (not IDLE).
- `done`  out  1  one-cycle pulse when a command completes.
- `model`  out  1  driver's modelled downstream state.
- `mismatch`  out  1  one-cycle pulse: `fb_out` differs from `model`.
- `err_cnt`  out  ERR_W  saturating count of mismatch cycles.

## Operation
- FSM states: IDLE, DRIVE, HOLD.
- IDLE: `tgt_ready`=1. Handshake completes on `tgt_valid && tgt_ready` at a rising edge. The driver latches `tgt_state` and `tgt_hold`, then:
  - If `tgt_state != model`, go to DRIVE.
  - Otherwise, if `tgt_hold != 0`, go to HOLD with count = `tgt_hold`.
  - Otherwise, stay in IDLE and pulse `done` the next cycle.
- DRIVE: lasts exactly one cycle.
  - Drives `j`=1 if the target is ON, or `k`=1 if the target is OFF.
  - At the end of the cycle, `model` takes the target value.
  - Next state is HOLD if the hold count is nonzero; otherwise IDLE, with `done` pulsed.
- HOLD: `j`=`k`=0. The counter decrements each cycle. When the count is 1, the next state is IDLE and `done` pulses.
- `j` and `k` are never both 1. Both are 0 outside DRIVE.
- `j`/`k` are decoded directly from the state and latched target; there is no extra register.
- `tgt_ready`=0 in DRIVE and HOLD. There is no queueing; an upstream `tgt_valid` simply waits.
- Reset values: FSM=IDLE, `model`=0 (OFF), `j`=`k`=0, `tgt_ready`=1, `busy`=0, `done`=0, `mismatch`=0, `err_cnt`=0.
- Reset asserted mid-command aborts the command and drops the latched command; `done` is not pulsed.
- Hold count `2^HOLD_W-1` is legal. The counter never wraps, because it is only loaded from a nonzero value.

## Timing
- Command accepted at edge E0:
  - DRIVE occupies cycle E0–E1, with `j`/`k` high.
  - The downstream machine samples the pulse at E1. `fb_out` and `model` both change after E1.
- Total busy cycles:
  - 1 + `tgt_hold` when a transition is required.
  - `tgt_hold` when no transition is required.
  - `done` is high in the cycle after the last busy cycle.
- Back-to-back: a new command is accepted in the first cycle `tgt_ready` is 1 after `done`'s predecessor edge. The minimum command period is 2 cycles (DRIVE, then IDLE).
- The checker compares `fb_out` with `model` every cycle outside reset. Both update on the same edge, so there is zero skew.

## Configuration
- `ONOFF_DRV_CHECK_EN` defined:
  - The checker is active.
  - On mismatch, `mismatch` pulses and `err_cnt` increments, saturating at all-ones.
  - `model` resynchronises to `fb_out` at the next edge, so later decisions use the actual downstream state.
- Undefined:
  - `fb_out` is ignored.
  - `mismatch`=0 and `err_cnt`=0 constantly.
  - `model` is driven only by DRIVE.

## Structure
- Shared package `onoff_pkg`: FSM state enum (IDLE, DRIVE, HOLD), constants ST_OFF=0 and ST_ON=1.
- Sub-module `onoff_checker`: compare logic, mismatch pulse, saturating `err_cnt`, and resync request. It is instantiated only under `ONOFF_DRV_CHECK_EN`.

## Test plan
- Reset, then a command with state=1, hold=3 → `j`=1 for exactly one cycle, `k`=0; `model`=1; `busy` for 4 cycles; `done` pulses once; `tgt_ready` low throughout.
- With model=1, a command with state=1, hold=0 → no `j`/`k` pulse; `done` the next cycle; `busy` never high.
- Commands state=0/hold=0 and state=1/hold=0 back-to-back with `tgt_valid` held → `k` pulse, then `j` pulse exactly 2 cycles apart; `j` and `k` never high together.
- `reset` driven low during HOLD of a hold=5 command → immediate IDLE, `model`=0, no `done`; the next command is accepted right after reset is released.
- With `ONOFF_DRV_CHECK_EN`, force `fb_out`=1 while `model`=0 → one `mismatch` pulse, `err_cnt`=1, `model`=1 the next cycle; a subsequent state=1 command produces no `j`.
- With `ONOFF_DRV_CHECK_EN`, hold `fb_out` mismatched for 300 cycles with ERR_W=8 → `err_cnt` saturates at 255.

Source files
------------

// File: rtl/onoff_pkg.sv
// rtl/onoff_pkg.sv - shared FSM state and ON/OFF constants for onoff_driver
package onoff_pkg;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_DRIVE = 2'd1,
        S_HOLD  = 2'd2
    } drv_state_t;

    localparam logic ST_OFF = 1'b0;
    localparam logic ST_ON  = 1'b1;

endpackage

// File: rtl/onoff_driver_if.sv
// rtl/onoff_driver_if.sv - target-state command handshake between upstream and onoff_driver
interface onoff_driver_if #(
    parameter int HOLD_W = 8
);
    logic              tgt_valid;
    logic              tgt_ready;
    logic              tgt_state;
    logic [HOLD_W-1:0] tgt_hold;

    modport master (output tgt_valid, output tgt_state, output tgt_hold, input tgt_ready);
    modport slave  (input tgt_valid, input tgt_state, input tgt_hold, output tgt_ready);
endinterface

// File: rtl/onoff_checker.sv
// rtl/onoff_checker.sv - downstream feedback checker, present only with ONOFF_DRV_CHECK_EN
`ifdef ONOFF_DRV_CHECK_EN
module onoff_checker #(
    parameter int ERR_W = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             fb_out_i,
    input  logic             model_i,
    output logic             mismatch_o,
    output logic [ERR_W-1:0] err_cnt_o,
    output logic             resync_o
);
    logic [ERR_W-1:0] err_cnt_q;

    // fb_out and model move on the same edge, so a plain same-cycle compare has no skew
    assign mismatch_o = rst_n && (fb_out_i != model_i);
    assign resync_o   = mismatch_o;
    assign err_cnt_o  = err_cnt_q;

    // Saturating count of mismatching cycles
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            err_cnt_q <= '0;
        end else if (mismatch_o && (err_cnt_q != {ERR_W{1'b1}})) begin
            err_cnt_q <= err_cnt_q + 1'b1;
        end
    end
endmodule
`endif

// File: rtl/onoff_driver.sv
// rtl/onoff_driver.sv - j/k pulse generator for the ON/OFF machine; checker enabled by ONOFF_DRV_CHECK_EN
module onoff_driver
    import onoff_pkg::*;
#(
    parameter int HOLD_W = 8,
    parameter int ERR_W  = 8
) (
    input  logic               clk,
    input  logic               reset,
    onoff_driver_if.slave      tgt,
    output logic               j,
    output logic               k,
    input  logic               fb_out,
    output logic               busy,
    output logic               done,
    output logic               model,
    output logic               mismatch,
    output logic [ERR_W-1:0]   err_cnt
);
    localparam logic [HOLD_W-1:0] HOLD_ONE = {{(HOLD_W-1){1'b0}}, 1'b1};

    drv_state_t        state_q;
    logic              tgt_q;
    logic [HOLD_W-1:0] cnt_q;
    logic              model_q;
    logic              done_q;
    logic              resync;

`ifdef ONOFF_DRV_CHECK_EN
    onoff_checker #(.ERR_W(ERR_W)) u_checker (
        .clk        (clk),
        .rst_n      (reset),
        .fb_out_i   (fb_out),
        .model_i    (model_q),
        .mismatch_o (mismatch),
        .err_cnt_o  (err_cnt),
        .resync_o   (resync)
    );
`else
    logic unused_fb;
    assign unused_fb = fb_out;
    assign resync    = 1'b0;
    assign mismatch  = 1'b0;
    assign err_cnt   = '0;
`endif

    // Pulses come straight from the state and latched target so DRIVE and j/k coincide
    assign j             = (state_q == S_DRIVE) && (tgt_q == ST_ON);
    assign k             = (state_q == S_DRIVE) && (tgt_q == ST_OFF);
    assign tgt.tgt_ready = (state_q == S_IDLE);
    assign busy          = (state_q != S_IDLE);
    assign done          = done_q;
    assign model         = model_q;

    // Command FSM, hold counter and downstream-state model
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= S_IDLE;
            tgt_q   <= ST_OFF;
            cnt_q   <= '0;
            model_q <= ST_OFF;
            done_q  <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (tgt.tgt_valid) begin
                        tgt_q <= tgt.tgt_state;
                        cnt_q <= tgt.tgt_hold;
                        if (tgt.tgt_state != model_q) begin
                            state_q <= S_DRIVE;
                        end else if (tgt.tgt_hold != '0) begin
                            state_q <= S_HOLD;
                        end else begin
                            done_q <= 1'b1;
                        end
                    end
                end
                S_DRIVE: begin
                    if (cnt_q != '0) begin
                        state_q <= S_HOLD;
                    end else begin
                        state_q <= S_IDLE;
                        done_q  <= 1'b1;
                    end
                end
                S_HOLD: begin
                    // Only ever loaded nonzero, so the count reaches 1 before it could wrap
                    if (cnt_q == HOLD_ONE) begin
                        state_q <= S_IDLE;
                        done_q  <= 1'b1;
                    end else begin
                        cnt_q <= cnt_q - 1'b1;
                    end
                end
                default: state_q <= S_IDLE;
            endcase

            // The pulse just issued defines the new downstream state; otherwise follow feedback
            if (state_q == S_DRIVE) begin
                model_q <= tgt_q;
            end else if (resync) begin
                model_q <= ~model_q;
            end
        end
    end
endmodule
